// File: rtl/pipe_stage_regs.sv
// ---------------------------------------------------------------------------
// pipe_stage_regs
//   Reusable inter-stage pipeline register for the 16-bit pipelined CPU
//   (F/D, D/X, X/M, M/W). It holds instr + oldPC + newPC, tracks a valid bit,
//   and supports stall (hold), flush (bubble insert), a ready/valid handshake
//   and a saturating count of stalled cycles.
//
//   Optional feature: define PIPE_SKID_EN to add a 1-entry skid buffer so that
//   in_ready is driven from a flop instead of combinationally from
//   out_ready/stall.
//
// Ports
//   clk          clock, all state updates on posedge
//   rst          synchronous active-high reset, dominates every other input
//   stall        hold stage contents (hazard unit)
//   flush        squash stage contents (branch mispredict), beats stall
//   in_valid     upstream payload valid
//   in_ready     stage accepts payload this cycle
//   instr_in     instruction in
//   oldPC_in     PC of the instruction
//   newPC_in     next/target PC
//   out_valid    stage holds a real instruction
//   out_ready    downstream accepts this cycle
//   instr_out    registered instruction (NOP_INSTR when not valid)
//   oldPC_out    registered oldPC
//   newPC_out    registered newPC
//   stall_count  cycles with stall=1 since reset, saturating
// ---------------------------------------------------------------------------
module pipe_stage_regs #(
  parameter int                 INSTR_W   = 16,
  parameter int                 PC_W      = 16,
  parameter logic [INSTR_W-1:0] NOP_INSTR = {INSTR_W{1'b0}},
  parameter int                 SCNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [PC_W-1:0]    oldPC_in,
  input  logic [PC_W-1:0]    newPC_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [PC_W-1:0]    oldPC_out,
  output logic [PC_W-1:0]    newPC_out,
  output logic [SCNT_W-1:0]  stall_count
);

  // The main register may take new contents when not stalled and either
  // empty or being drained downstream this cycle.
  logic advance;
  logic accept;

  // Source the main register loads from when it advances.
  logic               src_valid;
  logic [INSTR_W-1:0] src_instr;
  logic [PC_W-1:0]    src_old_pc;
  logic [PC_W-1:0]    src_new_pc;

  assign advance = ~stall & (out_ready | ~out_valid);
  assign accept  = in_valid & in_ready;

`ifdef PIPE_SKID_EN
  logic               skid_valid;
  logic [INSTR_W-1:0] skid_instr;
  logic [PC_W-1:0]    skid_old_pc;
  logic [PC_W-1:0]    skid_new_pc;

  // Ready depends only on skid occupancy (a flop) plus flush, which always
  // consumes and discards whatever is offered.
  assign in_ready = flush | ~skid_valid;

  // A full skid always drains first; in_ready is low then, so no input
  // competes with it and ordering is preserved.
  assign src_valid  = skid_valid | accept;
  assign src_instr  = skid_valid ? skid_instr  : instr_in;
  assign src_old_pc = skid_valid ? skid_old_pc : oldPC_in;
  assign src_new_pc = skid_valid ? skid_new_pc : newPC_in;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      skid_valid <= 1'b0;
    end else if (advance) begin
      // Either drains into main now or was empty and stays empty.
      skid_valid <= 1'b0;
    end else if (accept) begin
      skid_valid <= 1'b1;
    end
  end

  // NOTE: payload-only storage is not reset; skid_valid alone qualifies it,
  // so resetting the data would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (!rst && !flush && !advance && accept) begin
      skid_instr  <= instr_in;
      skid_old_pc <= oldPC_in;
      skid_new_pc <= newPC_in;
    end
  end
`else
  // Without a skid there is nowhere to park data, so ready follows the
  // main register's ability to advance (combinational from out_ready/stall).
  assign in_ready   = flush | advance;
  assign src_valid  = accept;
  assign src_instr  = instr_in;
  assign src_old_pc = oldPC_in;
  assign src_new_pc = newPC_in;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      instr_out   <= NOP_INSTR;
      oldPC_out   <= '0;
      newPC_out   <= '0;
      stall_count <= '0;
    end else begin
      // Saturate rather than wrap; flush leaves the count alone.
      if (stall && (stall_count != {SCNT_W{1'b1}})) begin
        stall_count <= stall_count + 1'b1;
      end

      if (flush) begin
        // Bubble insert: PCs keep their last values.
        out_valid <= 1'b0;
        instr_out <= NOP_INSTR;
      end else if (advance) begin
        if (src_valid) begin
          out_valid <= 1'b1;
          instr_out <= src_instr;
          oldPC_out <= src_old_pc;
          newPC_out <= src_new_pc;
        end else begin
          out_valid <= 1'b0;
          instr_out <= NOP_INSTR;
        end
      end
      // Otherwise stalled or back-pressured: everything holds.
    end
  end

endmodule
